// File: rtl/test_result_checker.sv
// ============================================================================
// Module   : test_result_checker
// Brief    : Snoops data-memory writes for an end-of-test sentinel, then reads
//            the answer region and compares it word by word with a golden store.
// Revision : 1.0
// ============================================================================
`default_nettype none

module test_result_checker #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = 16'hfffc,
    parameter logic [7:0]        HALT_BYTE    = 8'hff,
    parameter logic [ADDR_W-1:0] ANSWER_START = 16'h9000,
    parameter int                MAX_WORDS    = 256,
    parameter int                MAX_CYCLES   = 100000,
    localparam int               NW_W         = $clog2(MAX_WORDS + 1),
    localparam int               IDX_W        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [NW_W-1:0]     cfg_num_words,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [IDX_W-1:0]    gold_idx,
    input  logic [DATA_W-1:0]   gold_data,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    output logic [DATA_W-1:0]   first_err_exp,
    output logic [31:0]         cycle_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_CHECK   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [NW_W-1:0] c_max_words  = NW_W'(MAX_WORDS);
    localparam logic [31:0]     c_last_cycle = 32'(MAX_CYCLES - 1);

    state_t              r_state;
    logic [NW_W-1:0]     r_num_words;
    logic                r_cmp_valid;
    logic [ADDR_W-1:0]   r_cmp_addr;

    logic [NW_W-1:0]     w_num_clamped;
    logic                w_halt;
    logic                w_mismatch;
    logic [15:0]         w_err_next;
    logic                w_last_issue;
    logic                w_unused_bits;

    // Only lane 0 of the sentinel write matters; the other lanes are don't-care.
    assign w_unused_bits = &{1'b0, wr_strb, wr_data};

    always_comb begin
        w_num_clamped = (cfg_num_words > c_max_words) ? c_max_words : cfg_num_words;
        w_halt        = (r_state == ST_RUN) && wr_en && (wr_addr == HALT_ADDR)
                        && wr_strb[0] && (wr_data[7:0] == HALT_BYTE);
        w_mismatch    = r_cmp_valid && (rd_data != gold_data);
        w_err_next    = (w_mismatch && (err_cnt != 16'hffff)) ? err_cnt + 16'd1 : err_cnt;
        w_last_issue  = (NW_W'(gold_idx) + NW_W'(1)) == r_num_words;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_num_words    <= '0;
            r_cmp_valid    <= 1'b0;
            r_cmp_addr     <= '0;
            rd_en          <= 1'b0;
            rd_addr        <= '0;
            gold_idx       <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            cycle_cnt      <= '0;
        end else begin
            // Compare stage trails the issue stage by one cycle.
            r_cmp_valid <= rd_en;
            r_cmp_addr  <= rd_addr;
            if (w_mismatch) begin
                err_cnt <= w_err_next;
                if (err_cnt == 16'd0) begin
                    first_err_addr <= r_cmp_addr;
                    first_err_data <= rd_data;
                    first_err_exp  <= gold_data;
                end
            end

            case (r_state)
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (w_halt) begin
                        r_num_words <= w_num_clamped;
                        rd_addr     <= ANSWER_START;
                        gold_idx    <= '0;
                        if (w_num_clamped != '0) begin
                            r_state <= ST_CHECK;
                            rd_en   <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            pass    <= (w_err_next == 16'd0);
                        end
                    end else if (cycle_cnt == c_last_cycle) begin
                        r_state <= ST_TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (rd_en) begin
                        if (w_last_issue) begin
                            rd_en <= 1'b0;
                        end else begin
                            rd_addr  <= rd_addr + ADDR_W'(4);
                            gold_idx <= gold_idx + IDX_W'(1);
                        end
                    end else if (r_cmp_valid) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        pass    <= (w_err_next == 16'd0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_test_result_checker.sv
// ============================================================================
// Module   : tb_test_result_checker
// Brief    : Directed and randomized scenarios against a scenario-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_test_result_checker;

    localparam int MW = 8;
    localparam int MC = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic [3:0]  cfg_num_words;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  gold_idx;
    logic [31:0] gold_data;
    logic        done, pass, timeout;
    logic [15:0] err_cnt;
    logic [15:0] first_err_addr;
    logic [31:0] first_err_data, first_err_exp;
    logic [31:0] cycle_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] ans  [MW];
    logic [31:0] gold [MW];
    int          log_cyc  [$];
    logic [15:0] log_addr [$];
    logic [2:0]  log_idx  [$];

    always #5 clk = ~clk;

    test_result_checker #(.MAX_WORDS(MW), .MAX_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
        .wr_data(wr_data), .cfg_num_words(cfg_num_words), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .gold_idx(gold_idx),
        .gold_data(gold_data), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .first_err_exp(first_err_exp),
        .cycle_cnt(cycle_cnt)
    );

    // Answer memory and golden store: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data   <= ans[3'((rd_addr - 16'h9000) >> 2)];
            gold_data <= gold[gold_idx];
        end
    end

    always @(negedge clk) begin
        if (rd_en) begin
            log_cyc.push_back(cyc);
            log_addr.push_back(rd_addr);
            log_idx.push_back(gold_idx);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_strb       = '0;
        wr_data       = '0;
        cfg_num_words = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        log_cyc.delete();
        log_addr.delete();
        log_idx.delete();
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_first_err_addr", first_err_addr, 0);
    endtask

    task automatic sentinel(input logic [3:0] strb, input logic [7:0] b, input logic [3:0] cfg);
        wr_en         = 1'b1;
        wr_addr       = 16'hfffc;
        wr_strb       = strb;
        wr_data       = {24'h123456, b};
        cfg_num_words = cfg;
    endtask

    task automatic fill(input int err_pct);
        for (int i = 0; i < MW; i++) begin
            gold[i] = $urandom;
            ans[i]  = gold[i];
            if ($urandom_range(0, 99) < err_pct)
                ans[i] = gold[i] ^ (32'h1 << $urandom_range(0, 31));
        end
    endtask

    // halt < 0 means no sentinel is ever written.
    task automatic scenario(input string name, input int halt, input int cfg);
        int n, errs, fi, d, exp_cnt, n_reads;
        bit has_halt;
        has_halt = (halt >= 0) && (halt <= MC - 1);
        n        = (cfg > MW) ? MW : cfg;
        errs     = 0;
        fi       = -1;
        for (int i = 0; i < n; i++) begin
            if (ans[i] !== gold[i]) begin
                if (fi < 0) fi = i;
                errs++;
            end
        end
        if (!has_halt) errs = 0;
        n_reads = has_halt ? n : 0;
        d       = has_halt ? halt + ((n > 0) ? n + 2 : 1) : MC;
        exp_cnt = has_halt ? halt + 1 : MC;

        do_reset();
        for (int c = 0; c <= d + 2; c++) begin
            wr_en         = $urandom_range(0, 1);
            wr_addr       = 16'($urandom);
            wr_strb       = 4'($urandom);
            wr_data       = $urandom;
            cfg_num_words = 4'($urandom);
            if (wr_addr == 16'hfffc) wr_data[7:0] = 8'h00;
            if (has_halt && c == halt)          sentinel(4'b1111, 8'hff, 4'(cfg));
            else if (has_halt && c == halt - 2) sentinel(4'b1110, 8'hff, 4'd3);
            else if (has_halt && c == halt - 1) sentinel(4'b1111, 8'hfe, 4'd3);
            else if (has_halt && c == halt + 1) sentinel(4'b1111, 8'hff, 4'd2);

            if (c == d - 1) check({name, "_done_early"}, done, 0);
            if (c == d) begin
                check({name, "_done"}, done, 1);
                check({name, "_timeout"}, timeout, !has_halt);
                check({name, "_pass"}, pass, has_halt && errs == 0);
                check({name, "_err_cnt"}, err_cnt, errs);
                check({name, "_cycle_cnt"}, cycle_cnt, exp_cnt);
                check({name, "_rd_en"}, rd_en, 0);
                check({name, "_ferr_addr"}, first_err_addr, (errs > 0) ? 16'h9000 + 16'(4 * fi) : 16'h0);
                check({name, "_ferr_data"}, first_err_data, (errs > 0) ? ans[fi] : 32'h0);
                check({name, "_ferr_exp"}, first_err_exp, (errs > 0) ? gold[fi] : 32'h0);
            end
            if (c == d + 2) begin
                check({name, "_hold_done"}, done, 1);
                check({name, "_hold_cycle_cnt"}, cycle_cnt, exp_cnt);
                check({name, "_hold_err_cnt"}, err_cnt, errs);
            end
            tick();
        end
        idle_inputs();

        check({name, "_n_reads"}, log_addr.size(), n_reads);
        for (int i = 0; i < n_reads && i < log_addr.size(); i++) begin
            check({name, "_rd_addr"}, log_addr[i], 16'h9000 + 16'(4 * i));
            check({name, "_gold_idx"}, log_idx[i], i);
            check({name, "_rd_cycle"}, log_cyc[i], halt + 1 + i);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        fill(0);
        scenario("all_match", 10, 4);

        fill(0);
        gold[2] = 32'h0000_0005;
        ans[2]  = 32'hdead_beef;
        scenario("word2_bad", 10, 4);

        fill(30);
        scenario("timeout", -1, 4);

        fill(50);
        scenario("n_zero", 12, 0);

        fill(40);
        scenario("clamp", 6, 12);

        fill(40);
        scenario("halt_at_limit", MC - 1, 1);

        for (int r = 0; r < 6; r++) begin
            fill(35);
            scenario("random", $urandom_range(3, 40), $urandom_range(0, 12));
        end

        // Reset in the second CHECK cycle while a mismatching compare is pending.
        fill(0);
        ans[0] = ~gold[0];
        ans[1] = ~gold[1];
        do_reset();
        for (int c = 0; c < 5; c++) tick();
        sentinel(4'b1111, 8'hff, 4'd4);
        tick();
        idle_inputs();
        check("mid_check_rd_en", rd_en, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rd_en", rd_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_gold_idx", gold_idx, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_timeout", timeout, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_ferr_addr", first_err_addr, 0);
        check("abort_ferr_data", first_err_data, 0);
        check("abort_ferr_exp", first_err_exp, 0);
        check("abort_cycle_cnt", cycle_cnt, 0);
        tick();
        check("abort_restart_cnt", cycle_cnt, 1);
        check("abort_no_err", err_cnt, 0);
        check("abort_rd_en_after", rd_en, 0);
        sentinel(4'b1111, 8'hff, 4'd0);
        tick();
        idle_inputs();
        check("abort_rehalt_done", done, 1);
        check("abort_rehalt_pass", pass, 1);
        check("abort_rehalt_cnt", cycle_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/test_result_checker.md
TEST_RESULT_CHECKER -- requirements
Module: test_result_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the word width (multiple of 8).
REQ-003 SHALL have parameter HALT_ADDR, default 16'hfffc, meaning the byte address of the end-of-test sentinel.
REQ-004 SHALL have parameter HALT_BYTE, default 8'hff, meaning the sentinel value in byte lane 0.
REQ-005 SHALL have parameter ANSWER_START, default 16'h9000, meaning the byte address of the first answer word.
REQ-006 SHALL have parameter MAX_WORDS, default 256, meaning the largest answer-region size in words.
REQ-007 SHALL have parameter MAX_CYCLES, default 100000, meaning the run-phase timeout in clk cycles.
REQ-008 SHALL have port clk  in  1  system clock, all logic on the rising edge.
REQ-009 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-010 SHALL have port wr_en  in  1  snooped data-memory write strobe.
REQ-011 SHALL have port wr_addr  in  ADDR_W  snooped write byte address.
REQ-012 SHALL have port wr_strb  in  DATA_W/8  snooped byte enables.
REQ-013 SHALL have port wr_data  in  DATA_W  snooped write data.
REQ-014 SHALL have port cfg_num_words  in  clog2(MAX_WORDS+1)  number of answer words to check.
REQ-015 SHALL have port rd_en  out  1  answer-memory read request.
REQ-016 SHALL have port rd_addr  out  ADDR_W  answer-memory read byte address.
REQ-017 SHALL have port rd_data  in  DATA_W  read data, valid the cycle after rd_en.
REQ-018 SHALL have port gold_idx  out  clog2(MAX_WORDS)  golden-store index, issued with rd_en.
REQ-019 SHALL have port gold_data  in  DATA_W  golden word, valid the cycle after rd_en.
REQ-020 SHALL have ports done, pass, timeout  out  1 each  completion, all-match and timeout flags.
REQ-021 SHALL have port err_cnt  out  16  mismatch count.
REQ-022 SHALL have ports first_err_addr (ADDR_W), first_err_data (DATA_W), first_err_exp (DATA_W)  out  first-mismatch capture.
REQ-023 SHALL have port cycle_cnt  out  32  cycles spent in RUN.

Function
REQ-024 SHALL implement states RUN, CHECK, DONE, TIMEOUT; RUN is entered from reset.
REQ-025 RUN SHALL increment cycle_cnt by 1 every cycle, and cycle_cnt SHALL hold outside RUN.
REQ-026 Halt SHALL be detected when, in RUN, wr_en=1, wr_addr=HALT_ADDR, wr_strb[0]=1 and wr_data[7:0]=HALT_BYTE.
REQ-027 On halt, cfg_num_words SHALL be latched as N, and the next state SHALL be CHECK if N>0 or DONE if N=0.
REQ-028 In RUN without a halt, reaching cycle_cnt=MAX_CYCLES-1 SHALL move the state to TIMEOUT.
REQ-029 If halt and the timeout condition occur in the same cycle, halt SHALL win.
REQ-030 CHECK SHALL be pipelined at 1 word/cycle: for i=0..N-1, rd_en=1, rd_addr=ANSWER_START+4*i (mod 2^ADDR_W) and gold_idx=i on consecutive cycles.
REQ-031 The compare for word i SHALL use rd_data vs gold_data the following cycle, with exact DATA_W equality.
REQ-032 Each mismatch SHALL increment err_cnt, which SHALL saturate at 16'hffff.
REQ-033 The first mismatch only SHALL load first_err_addr, first_err_data and first_err_exp.
REQ-034 After the final compare the state SHALL be DONE, so done rises N+2 cycles after the halt cycle (1 cycle when N=0).
REQ-035 DONE SHALL drive done=1 and pass=(err_cnt==0), and SHALL be terminal until reset.
REQ-036 TIMEOUT SHALL drive done=1, timeout=1 and pass=0, and SHALL be terminal until reset.
REQ-037 Snooped writes outside RUN SHALL be ignored, including repeated sentinels.
REQ-038 rd_en SHALL be 0 outside CHECK.
REQ-039 cfg_num_words>MAX_WORDS SHALL be clamped to MAX_WORDS.

Reset
REQ-040 rst=1 SHALL force state RUN and clear rd_en, rd_addr, gold_idx, done, pass, timeout, err_cnt, first_err_*, cycle_cnt and N.
REQ-041 Reset asserted mid-CHECK SHALL abort any outstanding compare, so no err_cnt update occurs after reset.

Verification
REQ-042 Bench SHALL check: N=4, all words match, sentinel written at cycle 10 -> rd_addr 9000,9004,9008,900c on cycles 11-14; done=1, pass=1, err_cnt=0 at cycle 16.
REQ-043 Bench SHALL check: N=4, word 2 read 0xdeadbeef vs golden 0x00000005 -> err_cnt=1, first_err_addr=0x9008, first_err_data=0xdeadbeef, first_err_exp=0x00000005, pass=0.
REQ-044 Bench SHALL check: MAX_CYCLES=50 with no sentinel -> timeout=1, done=1, pass=0, cycle_cnt=50, rd_en never 1.
REQ-045 Bench SHALL check: sentinel with wr_strb=4'b1110, or with byte 0xfe -> no halt; a later 0xff with strb[0]=1 -> halt.
REQ-046 Bench SHALL check: N=0 -> done=1, pass=1 one cycle after the halt, with no reads issued.
REQ-047 Bench SHALL check: rst at the 2nd CHECK cycle -> all outputs cleared next cycle, state RUN, cycle_cnt restarts from 0.
